// File: rtl/comb_addr_seq_pkg.sv
// Shared types and default sizes for the feature/weight address sequencer.
package comb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } comb_seq_state_e;

    localparam int FEATURE_ROWS_DEF = 6;
    localparam int WEIGHT_COLS_DEF  = 3;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/comb_addr_seq_if.sv
// Control and index-stream bundle; the sequencer takes the master view.
interface comb_addr_seq_if #(
    parameter int ROW_W = 3,
    parameter int COL_W = 2
);
    logic             start;
    logic             abort;
    logic             ready;
    logic             valid;
    logic [ROW_W-1:0] row_idx;
    logic [COL_W-1:0] col_idx;
    logic             last;
    logic             busy;
    logic             done;
`ifdef COMB_SEQ_PERF_EN
    logic [15:0]      stall_cnt;
`endif

    modport master (
        input  start, abort, ready,
`ifdef COMB_SEQ_PERF_EN
        output stall_cnt,
`endif
        output valid, row_idx, col_idx, last, busy, done
    );

    modport slave (
        output start, abort, ready,
`ifdef COMB_SEQ_PERF_EN
        input  stall_cnt,
`endif
        input  valid, row_idx, col_idx, last, busy, done
    );
endinterface

// File: rtl/comb_addr_seq_wrap_counter.sv
// Modulo-MAX counter: clr wins over incr; wrap flags the increment that returns to 0.
// Latency: cnt updates one cycle after incr; wrap is combinational.
// Backpressure: none, the caller gates incr.
module wrap_counter #(
    parameter int MAX = 3,
    parameter int W   = (MAX > 1) ? $clog2(MAX) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         incr,
    output logic [W-1:0] cnt,
    output logic         wrap
);
    logic [W-1:0] cnt_q, cnt_d;
    logic         at_max;

    assign at_max = (cnt_q == W'(MAX - 1));
    assign wrap   = incr && at_max;
    assign cnt    = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (incr) begin
            cnt_d = at_max ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/comb_addr_seq.sv
// Walks (row, col) pairs over FEATURE_ROWS x WEIGHT_COLS, column innermost; COMB_SEQ_PERF_EN adds stall_cnt.
// Latency: first pair the cycle after start, done one cycle after the last pair is accepted.
// Backpressure: ready=0 holds the current pair; abort returns to idle next cycle.
module comb_addr_seq
    import comb_pkg::*;
#(
    parameter int FEATURE_ROWS = FEATURE_ROWS_DEF,
    parameter int WEIGHT_COLS  = WEIGHT_COLS_DEF,
    parameter int ROW_W        = idx_width(FEATURE_ROWS),
    parameter int COL_W        = idx_width(WEIGHT_COLS)
) (
    input  logic          clk,
    input  logic          reset,
    comb_addr_seq_if.master bus
);
    comb_seq_state_e  state_q, state_d;
    logic [ROW_W-1:0] row_cnt;
    logic [COL_W-1:0] col_cnt;
    logic             col_wrap;
    logic             row_wrap;
    logic             run;
    logic             accept;
    logic             cnt_clr;
    logic             pair_last;

    assign run       = (state_q == ST_RUN);
    assign accept    = run && bus.ready;
    // Holding the counters cleared outside RUN keeps every new sweep at (0,0).
    assign cnt_clr   = bus.abort || (state_q == ST_IDLE);
    assign pair_last = run && (row_cnt == ROW_W'(FEATURE_ROWS - 1))
                           && (col_cnt == COL_W'(WEIGHT_COLS - 1));

    wrap_counter #(.MAX(WEIGHT_COLS), .W(COL_W)) u_col_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .incr  (accept),
        .cnt   (col_cnt),
        .wrap  (col_wrap)
    );

    wrap_counter #(.MAX(FEATURE_ROWS), .W(ROW_W)) u_row_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .incr  (col_wrap),
        .cnt   (row_cnt),
        .wrap  (row_wrap)
    );

    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: if (bus.start) state_d = ST_RUN;
                ST_RUN:  if (accept && row_wrap) state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.valid   = run;
    assign bus.row_idx = row_cnt;
    assign bus.col_idx = col_cnt;
    assign bus.last    = pair_last;
    assign bus.busy    = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign bus.done    = (state_q == ST_DONE);

`ifdef COMB_SEQ_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == ST_IDLE) && bus.start && !bus.abort) begin
            stall_cnt_d = '0;
        end else if (run && !bus.ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`endif
endmodule
